// File: rtl/instr_enc_pkg.sv
// Shared constants for the RV32I instruction encoder/loader: opcodes, op-bit
// indices (same ordering as the core's decoder), funct fields, FSM states and
// small bit-scatter helpers for each instruction format.
package instr_enc_pkg;

    localparam int unsigned OP_W = 37;

    // Op-bit indices of the one-hot op bus
    localparam int unsigned OP_ADD  = 0,  OP_SUB  = 1,  OP_XOR  = 2,  OP_OR   = 3;
    localparam int unsigned OP_AND  = 4,  OP_SLL  = 5,  OP_SRL  = 6,  OP_SRA  = 7;
    localparam int unsigned OP_SLT  = 8,  OP_SLTU = 9,  OP_ADDI = 10, OP_XORI = 11;
    localparam int unsigned OP_ORI  = 12, OP_ANDI = 13, OP_SLLI = 14, OP_SRLI = 15;
    localparam int unsigned OP_SRAI = 16, OP_SLTI = 17, OP_SLTIU = 18, OP_LB  = 19;
    localparam int unsigned OP_LH   = 20, OP_LW   = 21, OP_LBU  = 22, OP_LHU  = 23;
    localparam int unsigned OP_SB   = 24, OP_SH   = 25, OP_SW   = 26, OP_BEQ  = 27;
    localparam int unsigned OP_BNE  = 28, OP_BLT  = 29, OP_BGE  = 30, OP_BLTU = 31;
    localparam int unsigned OP_BGEU = 32, OP_JAL  = 33, OP_JALR = 34, OP_LUI  = 35;
    localparam int unsigned OP_AUIPC = 36;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 values (ALU, loads/stores by size, branches)
    localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_B   = 3'd0, F3_H   = 3'd1, F3_W   = 3'd2;
    localparam logic [2:0] F3_BU  = 3'd4, F3_HU  = 3'd5;
    localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Op-stream handshake, session control and IMEM write bus of the encoder/loader.
interface instr_encoder_loader_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_cnt;
    logic              in_valid;
    logic              in_ready;
    logic [36:0]       in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err_illegal;
    logic              err_range;

    modport master (
        output start, base_addr, word_cnt, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_illegal, err_range
    );

    modport slave (
        input  start, base_addr, word_cnt, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_illegal, err_range
    );
endinterface

// File: rtl/instr_word_pack.sv
// Combinational op + fields -> RV32I word. Non-one-hot ops yield NOP_WORD and
// raise illegal_o. With INSTR_ENC_RANGE_CHECK_EN defined, range_o flags an
// immediate that does not fit its field; otherwise range_o is tied low.
module instr_word_pack
    import instr_enc_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic [OP_W-1:0] op_i,
    input  logic [4:0]      rd_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [31:0]     imm_i,
    output logic [31:0]     word_o,
    output logic            illegal_o,
    output logic            range_o
);

    int unsigned idx;

    assign illegal_o = ($countones(op_i) != 1);

    // Locate the set bit of a one-hot op
    always_comb begin
        idx = 0;
        for (int unsigned i = 0; i < OP_W; i++) begin
            if (op_i[i]) idx = i;
        end
    end

    // Format and field selection per op; unused register fields are zeroed
    always_comb begin
        word_o = NOP_WORD;
        if (!illegal_o) begin
            case (idx)
                OP_ADD:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_ADD,  rd_i, OPC_OP);
                OP_SUB:   word_o = enc_r(F7_ALT,  rs2_i, rs1_i, F3_ADD,  rd_i, OPC_OP);
                OP_XOR:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_XOR,  rd_i, OPC_OP);
                OP_OR:    word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_OR,   rd_i, OPC_OP);
                OP_AND:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_AND,  rd_i, OPC_OP);
                OP_SLL:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLL,  rd_i, OPC_OP);
                OP_SRL:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SR,   rd_i, OPC_OP);
                OP_SRA:   word_o = enc_r(F7_ALT,  rs2_i, rs1_i, F3_SR,   rd_i, OPC_OP);
                OP_SLT:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLT,  rd_i, OPC_OP);
                OP_SLTU:  word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLTU, rd_i, OPC_OP);
                OP_ADDI:  word_o = enc_i(imm_i[11:0], rs1_i, F3_ADD,  rd_i, OPC_OP_IMM);
                OP_XORI:  word_o = enc_i(imm_i[11:0], rs1_i, F3_XOR,  rd_i, OPC_OP_IMM);
                OP_ORI:   word_o = enc_i(imm_i[11:0], rs1_i, F3_OR,   rd_i, OPC_OP_IMM);
                OP_ANDI:  word_o = enc_i(imm_i[11:0], rs1_i, F3_AND,  rd_i, OPC_OP_IMM);
                OP_SLTI:  word_o = enc_i(imm_i[11:0], rs1_i, F3_SLT,  rd_i, OPC_OP_IMM);
                OP_SLTIU: word_o = enc_i(imm_i[11:0], rs1_i, F3_SLTU, rd_i, OPC_OP_IMM);
                OP_SLLI:  word_o = enc_r(F7_BASE, imm_i[4:0], rs1_i, F3_SLL, rd_i, OPC_OP_IMM);
                OP_SRLI:  word_o = enc_r(F7_BASE, imm_i[4:0], rs1_i, F3_SR,  rd_i, OPC_OP_IMM);
                OP_SRAI:  word_o = enc_r(F7_ALT,  imm_i[4:0], rs1_i, F3_SR,  rd_i, OPC_OP_IMM);
                OP_LB:    word_o = enc_i(imm_i[11:0], rs1_i, F3_B,  rd_i, OPC_LOAD);
                OP_LH:    word_o = enc_i(imm_i[11:0], rs1_i, F3_H,  rd_i, OPC_LOAD);
                OP_LW:    word_o = enc_i(imm_i[11:0], rs1_i, F3_W,  rd_i, OPC_LOAD);
                OP_LBU:   word_o = enc_i(imm_i[11:0], rs1_i, F3_BU, rd_i, OPC_LOAD);
                OP_LHU:   word_o = enc_i(imm_i[11:0], rs1_i, F3_HU, rd_i, OPC_LOAD);
                OP_SB:    word_o = enc_s(imm_i, rs2_i, rs1_i, F3_B);
                OP_SH:    word_o = enc_s(imm_i, rs2_i, rs1_i, F3_H);
                OP_SW:    word_o = enc_s(imm_i, rs2_i, rs1_i, F3_W);
                OP_BEQ:   word_o = enc_b(imm_i, rs2_i, rs1_i, F3_BEQ);
                OP_BNE:   word_o = enc_b(imm_i, rs2_i, rs1_i, F3_BNE);
                OP_BLT:   word_o = enc_b(imm_i, rs2_i, rs1_i, F3_BLT);
                OP_BGE:   word_o = enc_b(imm_i, rs2_i, rs1_i, F3_BGE);
                OP_BLTU:  word_o = enc_b(imm_i, rs2_i, rs1_i, F3_BLTU);
                OP_BGEU:  word_o = enc_b(imm_i, rs2_i, rs1_i, F3_BGEU);
                OP_JAL:   word_o = enc_j(imm_i, rd_i);
                OP_JALR:  word_o = enc_i(imm_i[11:0], rs1_i, 3'd0, rd_i, OPC_JALR);
                OP_LUI:   word_o = {imm_i[31:12], rd_i, OPC_LUI};
                OP_AUIPC: word_o = {imm_i[31:12], rd_i, OPC_AUIPC};
                default:  word_o = NOP_WORD;
            endcase
        end
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = imm_i;

    // Flag immediates that the target field cannot represent exactly
    always_comb begin
        range_o = 1'b0;
        if (!illegal_o) begin
            if ((idx >= OP_ADDI && idx <= OP_ANDI) || (idx >= OP_SLTI && idx <= OP_SW) ||
                idx == OP_JALR) begin
                range_o = (simm < -2048) || (simm > 2047);
            end else if (idx >= OP_SLLI && idx <= OP_SRAI) begin
                range_o = (imm_i[31:5] != '0);
            end else if (idx >= OP_BEQ && idx <= OP_BGEU) begin
                range_o = (simm < -4096) || (simm > 4094) || imm_i[0];
            end else if (idx == OP_JAL) begin
                range_o = (simm < -1048576) || (simm > 1048574) || imm_i[0];
            end else if (idx == OP_LUI || idx == OP_AUIPC) begin
                range_o = (imm_i[11:0] != '0);
            end
        end
    end
`else
    assign range_o = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Session FSM that accepts decoded ops, encodes them via instr_word_pack and
// writes them to consecutive IMEM word addresses one cycle after each accept.
// Optional immediate range checking is enabled by INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned CNT_W    = 10,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input logic                  clk,
    input logic                  reset,
    instr_encoder_loader_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_ill_q, err_ill_d;
    logic              err_rng_q, err_rng_d;

    logic [31:0] word;
    logic        illegal;
    logic        range_bad;
    logic        accept;

    instr_word_pack #(
        .NOP_WORD (NOP_WORD)
    ) u_pack (
        .op_i      (bus.in_op),
        .rd_i      (bus.in_rd),
        .rs1_i     (bus.in_rs1),
        .rs2_i     (bus.in_rs2),
        .imm_i     (bus.in_imm),
        .word_o    (word),
        .illegal_o (illegal),
        .range_o   (range_bad)
    );

    assign bus.in_ready = (state_q == StLoad) && (remaining_q != '0);
    assign accept       = bus.in_valid && bus.in_ready;

    // Next-state: session control, address/count tracking, write register, sticky errors
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        err_ill_d   = err_ill_q;
        err_rng_d   = err_rng_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d      = bus.base_addr;
                    remaining_d = bus.word_cnt;
                    err_ill_d   = 1'b0;
                    err_rng_d   = 1'b0;
                    state_d     = (bus.word_cnt == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    we_d        = 1'b1;
                    waddr_d     = addr_q;
                    wdata_d     = word;
                    addr_d      = addr_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
                    remaining_d = remaining_q - CNT_W'(1);
                    err_ill_d   = err_ill_q | illegal;
                    err_rng_d   = err_rng_q | range_bad;
                    if (remaining_q == CNT_W'(1)) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            err_ill_q   <= 1'b0;
            err_rng_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            err_ill_q   <= err_ill_d;
            err_rng_q   <= err_rng_d;
        end
    end

    assign bus.imem_we     = we_q;
    assign bus.imem_addr   = waddr_q;
    assign bus.imem_wdata  = wdata_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = (state_q == StDone);
    assign bus.err_illegal = err_ill_q;
    assign bus.err_range   = err_rng_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader. Range-error
// expectations follow INSTR_ENC_RANGE_CHECK_EN.
module tb_instr_encoder_loader;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   w0, d0;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam logic EXP_RNG = 1'b1;
`else
    localparam logic EXP_RNG = 1'b0;
`endif

    instr_encoder_loader_if #(.ADDR_W(10), .CNT_W(10)) bus ();

    instr_encoder_loader #(
        .ADDR_W   (10),
        .CNT_W    (10),
        .NOP_WORD (32'h00000013)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count write strobes and done pulses away from the active edge
    always @(negedge clk) begin
        if (bus.imem_we) wr_cnt++;
        if (bus.done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [36:0] oh(input int idx);
        logic [36:0] one;
        one = 37'd1;
        return one << idx;
    endfunction

    task automatic do_start(input logic [9:0] base, input logic [9:0] cnt);
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.word_cnt = cnt;
        tick();
        bus.start = 1'b0;
    endtask

    // Present one op (after an optional idle gap), wait for accept, check the write
    task automatic send(input string tag, input logic [36:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [9:0] ea, input logic [31:0] ew, input int gap);
        bit ok;
        repeat (gap) tick();
        bus.in_op = op;
        bus.in_rd = rd;
        bus.in_rs1 = rs1;
        bus.in_rs2 = rs2;
        bus.in_imm = imm;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk({tag, "_accept"}, 64'(ok), 64'd1);
        if (ok) begin
            chk({tag, "_we"}, 64'(bus.imem_we), 64'd1);
            chk({tag, "_addr"}, 64'(bus.imem_addr), 64'(ea));
            chk({tag, "_data"}, 64'(bus.imem_wdata), 64'(ew));
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_cnt = '0;
        bus.in_valid = 1'b0;
        bus.in_op = '0;
        bus.in_rd = '0;
        bus.in_rs1 = '0;
        bus.in_rs2 = '0;
        bus.in_imm = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_outputs", {bus.in_ready, bus.imem_we, bus.busy, bus.done, bus.err_illegal,
                            bus.err_range, bus.imem_addr, bus.imem_wdata}, 64'd0);

        // Session 1: wrap-around addressing, done with final write
        do_start(10'h3FE, 10'd3);
        chk("s1_busy", 64'(bus.busy), 64'd1);
        chk("s1_ready", 64'(bus.in_ready), 64'd1);
        send("add", oh(0), 5'd3, 5'd1, 5'd2, 32'd0, 10'h3FE, 32'h002081B3, 0);
        send("addi", oh(10), 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 10'h3FF, 32'hFFF00093, 0);
        send("sw", oh(26), 5'd0, 5'd1, 5'd2, 32'd8, 10'h000, 32'h0020A423, 0);
        chk("s1_done", 64'(bus.done), 64'd1);
        chk("s1_ready_off", 64'(bus.in_ready), 64'd0);
        tick();
        chk("s1_idle", {bus.done, bus.busy, bus.imem_we}, 64'd0);

        // Session 2: B/J/shift/U formats, start while busy ignored
        d0 = done_cnt;
        do_start(10'h010, 10'd4);
        send("beq", oh(27), 5'd0, 5'd1, 5'd2, -32'sd4, 10'h010, 32'hFE208EE3, 0);
        bus.start = 1'b1;
        bus.base_addr = 10'h200;
        bus.word_cnt = 10'd1;
        send("jal", oh(33), 5'd1, 5'd0, 5'd0, 32'd2048, 10'h011, 32'h001000EF, 0);
        bus.start = 1'b0;
        chk("s2_busy_kept", 64'(bus.busy), 64'd1);
        send("srai", oh(16), 5'd5, 5'd6, 5'd0, 32'd3, 10'h012, 32'h40335293, 1);
        send("lui", oh(35), 5'd2, 5'd0, 5'd0, 32'h12345000, 10'h013, 32'h12345137, 2);
        chk("s2_done", 64'(bus.done), 64'd1);
        chk("s2_no_rng", 64'(bus.err_range), 64'd0);
        tick();
        chk("s2_done_once", 64'(done_cnt - d0), 64'd1);

        // Session 3: illegal ops emit NOP and set the sticky flag
        do_start(10'h100, 10'd3);
        send("zero_op", 37'd0, 5'd1, 5'd2, 5'd3, 32'd5, 10'h100, 32'h00000013, 0);
        chk("ill_set", 64'(bus.err_illegal), 64'd1);
        send("two_hot", oh(0) | oh(1), 5'd1, 5'd2, 5'd3, 32'd0, 10'h101, 32'h00000013, 0);
        send("andi", oh(13), 5'd7, 5'd8, 5'd9, 32'h0F0, 10'h102, 32'h0F047393, 0);
        chk("ill_sticky", 64'(bus.err_illegal), 64'd1);
        tick();

        // Count 0: done one cycle after start, no write, illegal flag cleared
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(10'h055, 10'd0);
        chk("c0_done", {bus.done, bus.imem_we, bus.in_ready}, 64'b100);
        chk("ill_cleared", 64'(bus.err_illegal), 64'd0);
        tick();
        chk("c0_idle", {bus.done, bus.busy}, 64'd0);
        tick();
        chk("c0_no_write", 64'(wr_cnt - w0), 64'd0);
        chk("c0_one_done", 64'(done_cnt - d0), 64'd1);

        // Reset mid-session after two accepts with gaps
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(10'h050, 10'd4);
        send("r_or", oh(3), 5'd4, 5'd5, 5'd6, 32'd0, 10'h050, 32'h0062E233, 2);
        send("r_lw", oh(21), 5'd3, 5'd2, 5'd0, 32'd16, 10'h051, 32'h01012183, 3);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op = oh(0);
        tick();
        reset = 1'b0;
        chk("mid_rst_outputs", {bus.in_ready, bus.imem_we, bus.busy, bus.done,
                                bus.err_illegal, bus.err_range, bus.imem_addr,
                                bus.imem_wdata}, 64'd0);
        repeat (4) tick();
        bus.in_valid = 1'b0;
        chk("mid_rst_writes", 64'(wr_cnt - w0), 64'd2);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("mid_rst_idle", {bus.busy, bus.in_ready}, 64'd0);

        // Out-of-range immediates: truncated word always, flag only with the feature
        do_start(10'h020, 10'd1);
        send("addi_2048", oh(10), 5'd0, 5'd0, 5'd0, 32'd2048, 10'h020, 32'h80000013, 0);
        chk("rng_addi", 64'(bus.err_range), 64'(EXP_RNG));
        tick();
        do_start(10'h021, 10'd1);
        chk("rng_cleared", 64'(bus.err_range), 64'd0);
        send("beq_odd", oh(27), 5'd0, 5'd0, 5'd0, 32'd3, 10'h021, 32'h00000163, 0);
        chk("rng_beq", 64'(bus.err_range), 64'(EXP_RNG));
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
